uart_rx_word: RTL and testbench
===============================

# uart_rx_word

Oversampling UART receiver with word assembly. It is the receive-side neighbour of the UART transmit path: it consumes the serial line driven by the transmitter, recovers bytes using the shared `i_stick` baud tick, and packs consecutive bytes into little-endian words (e.g. 32-bit floating-point operands/results) for the downstream compute or checker logic. Framing errors are flagged and resynchronise the word assembler.

## Interface
- `SIZE_DATA`, 8, bits per UART character.
- `OVER_SAMPLE`, 16, `i_stick` ticks per bit period; even, ≥ 4.
- `BYTES_PER_WORD`, 4, characters per assembled word; ≥ 1.
- `i_clk`  in  1  system clock; single clock domain.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_stick`  in  1  one-cycle strobe at baud × OVER_SAMPLE.
- `i_rx_serial`  in  1  asynchronous serial line; idle high, LSB first, 1 start bit, 1 stop bit, no parity.
- `i_clear`  in  1  synchronous clear of the partial word.
- `o_rx_data`  out  SIZE_DATA  last good character.
- `o_rx_valid`  out  1  one-cycle pulse: `o_rx_data` updated.
- `o_frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `o_word`  out  SIZE_DATA×BYTES_PER_WORD  last completed word.
- `o_word_valid`  out  1  one-cycle pulse: `o_word` updated.
- `o_busy`  out  1  high whenever FSM is not IDLE.

## Operation
- Reset values: `o_rx_data`=0, `o_rx_valid`=0, `o_frame_err`=0, `o_word`=0, `o_word_valid`=0, `o_busy`=0; synchroniser flops = 1; FSM=IDLE; tick counter = 0; bit index = 0; byte index = 0.
- `i_rx_serial` passes through a 2-flop synchroniser (reset to 1); the FSM sees only the synchronised line `rx_s`.
- All FSM and counter activity advances only on cycles with `i_stick`=1; other cycles hold state.
- IDLE: on a tick with `rx_s`=0, go to START, counter=0.
- START: each tick increments counter; at counter = OVER_SAMPLE/2−1, sample `rx_s`: 0 → DATA (counter=0, bit index=0); 1 → IDLE (glitch rejected, no output).
- DATA: at counter = OVER_SAMPLE−1, sample `rx_s` into the shift register MSB with a right shift (LSB-first), counter=0, bit index+1; after SIZE_DATA samples go to STOP.
- STOP: at counter = OVER_SAMPLE−1, sample `rx_s`: 1 → load `o_rx_data`, pulse `o_rx_valid`, feed assembler; 0 → pulse `o_frame_err`, drop the character, and reset the byte index to 0. Either case → IDLE; a new start bit is accepted from the next tick onward.
- Assembler: a good character with byte index k is written to word buffer bits [k×SIZE_DATA +: SIZE_DATA]. When k = BYTES_PER_WORD−1, `o_word` = completed buffer, pulse `o_word_valid`, index wraps to 0; otherwise index+1.
- `i_clear`: byte index ← 0 and buffer ← 0. If it coincides with a good stop sample, `o_rx_valid` still pulses, but the character is discarded from assembly. This takes precedence over word completion, so no `o_word_valid` is produced.
- `i_clear` does not affect the receive FSM or `o_rx_data`/`o_word`.
- `o_rx_data` and `o_word` hold their values between pulses.

## Timing
- All outputs are registered. Pulses are exactly one `i_clk` cycle wide, asserted the cycle after the edge that processes the stop-bit tick.
- `o_word_valid` is coincident with the `o_rx_valid` of the final byte.
- Input latency: 2 `i_clk` cycles through the synchroniser, plus up to 1 tick period to detect the start bit.
- Sampling points relative to start-bit detection: start bit verified after OVER_SAMPLE/2 ticks (mid-bit). Data bit n is sampled at OVER_SAMPLE/2 + (n+1)×OVER_SAMPLE ticks. Stop bit is sampled at OVER_SAMPLE/2 + (SIZE_DATA+1)×OVER_SAMPLE ticks.
- `o_frame_err` and `o_rx_valid` are never asserted together.
- Asserting `i_rst` at any point, including mid-frame, immediately forces all reset values; no pulse is generated for the interrupted character.
- Back-to-back frames with no idle gap must be received without loss.

## Test plan
- Common bench setup: `i_stick` every 4 cycles, OVER_SAMPLE=16, ideal-rate stimulus.
- Single character 0xA5 → `o_rx_data`=0xA5, one `o_rx_valid` pulse, `o_frame_err`=0, `o_word_valid`=0.
- Characters 0x00, 0x00, 0x80, 0x3F back-to-back → four `o_rx_valid` pulses; `o_word`=32'h3F80_0000 with `o_word_valid` on the 4th pulse; next 4 bytes 0xDB,0x0F,0x49,0x40 → `o_word`=32'h4049_0FDB.
- 0x55 sent with stop bit = 0 → `o_frame_err` pulse, no `o_rx_valid`, `o_rx_data` unchanged. Then send 2 good bytes before the error and 4 good bytes after it → one `o_word_valid`, containing only the 4 post-error bytes.
- Line low for 4 ticks then high (glitch) → FSM returns to IDLE, `o_busy` drops, no pulses; a following 0x3C is received correctly.
- `i_clear` after 2 of 4 bytes, then 4 bytes 0x11,0x22,0x33,0x44 → `o_word`=32'h4433_2211.
- `i_rst` asserted mid-DATA, then a good 0x7E → all outputs at reset values during reset, then `o_rx_data`=0x7E.

Source files
------------

// File: rtl/uart_rx_word_if.sv
// uart_rx_word bus: serial/tick/clear inputs and
// character/word result outputs of the receiver.
interface uart_rx_word_if #(
  parameter int SIZE_DATA      = 8,
  parameter int BYTES_PER_WORD = 4
);
  logic                                i_stick;
  logic                                i_rx_serial;
  logic                                i_clear;
  logic [SIZE_DATA-1:0]                o_rx_data;
  logic                                o_rx_valid;
  logic                                o_frame_err;
  logic [SIZE_DATA*BYTES_PER_WORD-1:0] o_word;
  logic                                o_word_valid;
  logic                                o_busy;

  modport slave (
    input  i_stick, i_rx_serial, i_clear,
    output o_rx_data, o_rx_valid, o_frame_err,
    output o_word, o_word_valid, o_busy
  );

  modport master (
    output i_stick, i_rx_serial, i_clear,
    input  o_rx_data, o_rx_valid, o_frame_err,
    input  o_word, o_word_valid, o_busy
  );
endinterface

// File: rtl/uart_rx_word.sv
// Oversampling UART receiver packing characters into LE words.
// Ports: i_clk, i_rst (async high), bus (slave): i_stick baud
// strobe, i_rx_serial line, i_clear partial-word clear;
// o_rx_data/o_rx_valid char, o_frame_err, o_word/o_word_valid,
// o_busy (FSM not idle).
module uart_rx_word #(
  parameter int SIZE_DATA      = 8,
  parameter int OVER_SAMPLE    = 16,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  uart_rx_word_if.slave  bus
);
  localparam int CW = $clog2(OVER_SAMPLE);
  localparam int BW = (SIZE_DATA > 1) ? $clog2(SIZE_DATA) : 1;
  localparam int KW =
    (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int WW = SIZE_DATA * BYTES_PER_WORD;

  localparam logic [CW-1:0] HALF_END  = CW'(OVER_SAMPLE/2 - 1);
  localparam logic [CW-1:0] BIT_END   = CW'(OVER_SAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(SIZE_DATA - 1);
  localparam logic [KW-1:0] LAST_BYTE = KW'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic                 rx_meta, rx_s;
  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_idx, bit_n;
  logic [SIZE_DATA-1:0] shreg, sh_n;
  logic                 good, ferr;
  logic [KW-1:0]        byte_idx;
  logic [WW-1:0]        word_buf, word_n;
  logic                 last_byte;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.i_rx_serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = shreg;
    good    = 1'b0;
    ferr    = 1'b0;
    if (bus.i_stick) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            cnt_n   = '0;
          end
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt_n   = '0;
            bit_n   = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt_n = '0;
            sh_n  = {rx_s, shreg[SIZE_DATA-1:1]};
            if (bit_idx == LAST_BIT) begin
              bit_n   = '0;
              state_n = STOP;
            end else begin
              bit_n = bit_idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_END) begin
            cnt_n   = '0;
            state_n = IDLE;
            good    = rx_s;
            ferr    = !rx_s;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    word_n = word_buf;
    word_n[int'(byte_idx)*SIZE_DATA +: SIZE_DATA] = shreg;
    last_byte = (byte_idx == LAST_BYTE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_rx_data    <= '0;
      bus.o_rx_valid   <= 1'b0;
      bus.o_frame_err  <= 1'b0;
      bus.o_word       <= '0;
      bus.o_word_valid <= 1'b0;
      bus.o_busy       <= 1'b0;
      byte_idx         <= '0;
      word_buf         <= '0;
    end else begin
      bus.o_rx_valid   <= good;
      bus.o_frame_err  <= ferr;
      bus.o_word_valid <= 1'b0;
      bus.o_busy       <= (state_n != IDLE);
      if (good)
        bus.o_rx_data <= shreg;
      // clear wins over both error resync and word completion
      if (bus.i_clear) begin
        byte_idx <= '0;
        word_buf <= '0;
      end else if (ferr) begin
        byte_idx <= '0;
      end else if (good) begin
        word_buf <= word_n;
        if (last_byte) begin
          bus.o_word       <= word_n;
          bus.o_word_valid <= 1'b1;
          byte_idx         <= '0;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_word.sv
// Self-checking bench for uart_rx_word.
// Scoreboard model builds expected chars/words from sent frames.
module tb_uart_rx_word;
  localparam int SD      = 8;
  localparam int OS      = 16;
  localparam int BPW     = 4;
  localparam int BIT_CYC = OS * 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_word_if #(.SIZE_DATA(SD), .BYTES_PER_WORD(BPW)) bus ();

  uart_rx_word #(
    .SIZE_DATA(SD), .OVER_SAMPLE(OS), .BYTES_PER_WORD(BPW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  rx_got[$];
  logic [7:0]  exp_rx[$];
  logic [7:0]  mpart[$];
  logic [31:0] word_got[$];
  logic [31:0] exp_word[$];
  int ferr_got, exp_ferr, both_got, wv_alone;
  logic [7:0] exp_last = 8'h00;

  initial begin
    bus.i_rx_serial = 1'b1;
    bus.i_clear     = 1'b0;
    bus.i_stick     = 1'b0;
  end

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 4;
      bus.i_stick = (ph == 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_rx_valid === 1'b1) rx_got.push_back(bus.o_rx_data);
      if (bus.o_frame_err === 1'b1) ferr_got++;
      if (bus.o_word_valid === 1'b1) word_got.push_back(bus.o_word);
      if (bus.o_rx_valid === 1'b1 && bus.o_frame_err === 1'b1)
        both_got++;
      if (bus.o_word_valid === 1'b1 && bus.o_rx_valid !== 1'b1)
        wv_alone++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_reset();
    rx_got.delete();
    exp_rx.delete();
    word_got.delete();
    exp_word.delete();
    ferr_got = 0;
    exp_ferr = 0;
    both_got = 0;
    wv_alone = 0;
  endtask

  // Reference: good chars accumulate; every BPW of them form a
  // little-endian word; a framing error or clear drops the partial.
  task automatic m_frame(input logic [7:0] b, input bit ok);
    logic [31:0] w;
    if (ok) begin
      exp_rx.push_back(b);
      exp_last = b;
      mpart.push_back(b);
      if (mpart.size() == BPW) begin
        w = '0;
        for (int i = 0; i < BPW; i++)
          w = w | (32'(mpart[i]) << (8 * i));
        exp_word.push_back(w);
        mpart.delete();
      end
    end else begin
      exp_ferr++;
      mpart.delete();
    end
  endtask

  task automatic clear_pulse();
    bus.i_clear = 1'b1;
    wait_cyc(1);
    bus.i_clear = 1'b0;
    mpart.delete();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ok);
    bus.i_rx_serial = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      bus.i_rx_serial = b[i];
      wait_cyc(BIT_CYC);
    end
    bus.i_rx_serial = ok;
    wait_cyc(BIT_CYC);
    bus.i_rx_serial = 1'b1;
    m_frame(b, ok);
    if (!ok) wait_cyc(2 * BIT_CYC);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cyc(2);
    n_vec += 6;
    if (bus.o_rx_data !== 8'h00) begin
      n_err++; $display("FAIL reset_rx_data got %h want 00", bus.o_rx_data);
    end
    if (bus.o_rx_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_rx_valid got %b want 0", bus.o_rx_valid);
    end
    if (bus.o_frame_err !== 1'b0) begin
      n_err++; $display("FAIL reset_frame_err got %b want 0", bus.o_frame_err);
    end
    if (bus.o_word !== 32'h0) begin
      n_err++; $display("FAIL reset_word got %h want 0", bus.o_word);
    end
    if (bus.o_word_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_word_valid got %b want 0", bus.o_word_valid);
    end
    if (bus.o_busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy got %b want 0", bus.o_busy);
    end
    rst = 1'b0;
    mpart.delete();
    exp_last = 8'h00;
    wait_cyc(4);
  endtask

  task automatic test_single();
    sb_reset();
    clear_pulse();
    send_frame(8'hA5, 1'b1);
    wait_cyc(8);
    n_vec += 5;
    if (rx_got.size() != 1) begin
      n_err++; $display("FAIL single_count got %0d want 1", rx_got.size());
    end
    if ((rx_got.size() > 0 ? rx_got[0] : 8'hxx) !== 8'hA5) begin
      n_err++; $display("FAIL single_char got %h want a5",
                        rx_got.size() > 0 ? rx_got[0] : 8'hxx);
    end
    if (bus.o_rx_data !== 8'hA5) begin
      n_err++; $display("FAIL single_hold got %h want a5", bus.o_rx_data);
    end
    if (ferr_got != 0) begin
      n_err++; $display("FAIL single_ferr got %0d want 0", ferr_got);
    end
    if (word_got.size() != 0) begin
      n_err++; $display("FAIL single_word got %0d want 0", word_got.size());
    end
  endtask

  task automatic test_words();
    logic [7:0] seq [8];
    seq = '{8'h00, 8'h00, 8'h80, 8'h3F, 8'hDB, 8'h0F, 8'h49, 8'h40};
    sb_reset();
    clear_pulse();
    foreach (seq[i]) send_frame(seq[i], 1'b1);
    wait_cyc(8);
    n_vec += 5;
    if (rx_got.size() != 8) begin
      n_err++; $display("FAIL words_chars got %0d want 8", rx_got.size());
    end
    if (word_got.size() != 2) begin
      n_err++; $display("FAIL words_count got %0d want 2", word_got.size());
    end
    if ((word_got.size() > 0 ? word_got[0] : 'x) !== 32'h3F80_0000) begin
      n_err++; $display("FAIL words_w0 got %h want 3f800000",
                        word_got.size() > 0 ? word_got[0] : 'x);
    end
    if ((word_got.size() > 1 ? word_got[1] : 'x) !== 32'h4049_0FDB) begin
      n_err++; $display("FAIL words_w1 got %h want 40490fdb",
                        word_got.size() > 1 ? word_got[1] : 'x);
    end
    if (wv_alone != 0) begin
      n_err++; $display("FAIL words_coincide got %0d want 0", wv_alone);
    end
  endtask

  task automatic test_frame_err();
    sb_reset();
    clear_pulse();
    send_frame(8'h55, 1'b0);
    wait_cyc(8);
    n_vec += 3;
    if (ferr_got != 1) begin
      n_err++; $display("FAIL ferr_pulse got %0d want 1", ferr_got);
    end
    if (rx_got.size() != 0) begin
      n_err++; $display("FAIL ferr_valid got %0d want 0", rx_got.size());
    end
    if (bus.o_rx_data !== exp_last) begin
      n_err++; $display("FAIL ferr_hold got %h want %h", bus.o_rx_data, exp_last);
    end
    for (int i = 0; i < 2; i++) send_frame(8'($urandom), 1'b1);
    send_frame(8'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1);
    wait_cyc(8);
    n_vec += 3;
    if (ferr_got != 2) begin
      n_err++; $display("FAIL ferr_total got %0d want 2", ferr_got);
    end
    if (word_got.size() != 1 || exp_word.size() != 1) begin
      n_err++; $display("FAIL ferr_words got %0d want 1", word_got.size());
    end
    if ((word_got.size() > 0 ? word_got[0] : 'x) !== exp_word[0]) begin
      n_err++; $display("FAIL ferr_word got %h want %h",
                        word_got.size() > 0 ? word_got[0] : 'x, exp_word[0]);
    end
  endtask

  task automatic test_glitch();
    sb_reset();
    bus.i_rx_serial = 1'b0;
    wait_cyc(16);
    bus.i_rx_serial = 1'b1;
    wait_cyc(4);
    n_vec++;
    if (bus.o_busy !== 1'b1) begin
      n_err++; $display("FAIL glitch_busy_hi got %b want 1", bus.o_busy);
    end
    wait_cyc(60);
    n_vec += 2;
    if (bus.o_busy !== 1'b0) begin
      n_err++; $display("FAIL glitch_busy_lo got %b want 0", bus.o_busy);
    end
    if (rx_got.size() != 0 || ferr_got != 0) begin
      n_err++; $display("FAIL glitch_pulses got %0d/%0d want 0/0",
                        rx_got.size(), ferr_got);
    end
    send_frame(8'h3C, 1'b1);
    wait_cyc(8);
    n_vec++;
    if ((rx_got.size() == 1 ? rx_got[0] : 8'hxx) !== 8'h3C) begin
      n_err++; $display("FAIL glitch_after got %h want 3c",
                        rx_got.size() > 0 ? rx_got[0] : 8'hxx);
    end
  endtask

  task automatic test_clear();
    sb_reset();
    clear_pulse();
    send_frame(8'($urandom), 1'b1);
    send_frame(8'($urandom), 1'b1);
    clear_pulse();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    wait_cyc(8);
    n_vec += 2;
    if (word_got.size() != 1) begin
      n_err++; $display("FAIL clear_count got %0d want 1", word_got.size());
    end
    if ((word_got.size() > 0 ? word_got[0] : 'x) !== 32'h4433_2211) begin
      n_err++; $display("FAIL clear_word got %h want 44332211",
                        word_got.size() > 0 ? word_got[0] : 'x);
    end
  endtask

  task automatic test_rst_mid();
    sb_reset();
    bus.i_rx_serial = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 3; i++) begin
      bus.i_rx_serial = 1'($urandom);
      wait_cyc(BIT_CYC);
    end
    n_vec++;
    if (bus.o_busy !== 1'b1) begin
      n_err++; $display("FAIL rstmid_busy got %b want 1", bus.o_busy);
    end
    rst = 1'b1;
    #1;
    n_vec += 2;
    if (bus.o_busy !== 1'b0 || bus.o_rx_valid !== 1'b0 ||
        bus.o_frame_err !== 1'b0 || bus.o_word_valid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_flags got %b%b%b%b want 0000",
                        bus.o_busy, bus.o_rx_valid,
                        bus.o_frame_err, bus.o_word_valid);
    end
    if (bus.o_rx_data !== 8'h00 || bus.o_word !== 32'h0) begin
      n_err++; $display("FAIL rstmid_data got %h/%h want 0/0",
                        bus.o_rx_data, bus.o_word);
    end
    bus.i_rx_serial = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    mpart.delete();
    exp_last = 8'h00;
    wait_cyc(BIT_CYC);
    send_frame(8'h7E, 1'b1);
    wait_cyc(8);
    n_vec += 2;
    if (rx_got.size() != 1 || ferr_got != 0) begin
      n_err++; $display("FAIL rstmid_count got %0d/%0d want 1/0",
                        rx_got.size(), ferr_got);
    end
    if (bus.o_rx_data !== 8'h7E) begin
      n_err++; $display("FAIL rstmid_char got %h want 7e", bus.o_rx_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      sb_reset();
      clear_pulse();
      for (int f = 0; f < 12; f++) begin
        if ($urandom_range(0, 5) == 0) clear_pulse();
        send_frame(8'($urandom), $urandom_range(0, 7) != 0);
        if ($urandom_range(0, 2) == 0) wait_cyc($urandom_range(1, 100));
      end
      wait_cyc(8);
      n_vec += 4;
      if (rx_got.size() != exp_rx.size()) begin
        n_err++; $display("FAIL b2b_chars got %0d want %0d",
                          rx_got.size(), exp_rx.size());
      end
      if (word_got.size() != exp_word.size()) begin
        n_err++; $display("FAIL b2b_words got %0d want %0d",
                          word_got.size(), exp_word.size());
      end
      if (ferr_got != exp_ferr) begin
        n_err++; $display("FAIL b2b_ferr got %0d want %0d", ferr_got, exp_ferr);
      end
      if (both_got != 0 || wv_alone != 0) begin
        n_err++; $display("FAIL b2b_overlap got %0d/%0d want 0/0",
                          both_got, wv_alone);
      end
      for (int i = 0; i < exp_rx.size(); i++) begin
        n_vec++;
        if ((i < rx_got.size() ? rx_got[i] : 8'hxx) !== exp_rx[i]) begin
          n_err++; $display("FAIL b2b_char[%0d] got %h want %h", i,
                            i < rx_got.size() ? rx_got[i] : 8'hxx, exp_rx[i]);
        end
      end
      for (int i = 0; i < exp_word.size(); i++) begin
        n_vec++;
        if ((i < word_got.size() ? word_got[i] : 'x) !== exp_word[i]) begin
          n_err++; $display("FAIL b2b_word[%0d] got %h want %h", i,
                            i < word_got.size() ? word_got[i] : 'x, exp_word[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_words();
    test_frame_err();
    test_glitch();
    test_clear();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
